mem_burst_seq: RTL and testbench

- Parametrised multi-cycle load/store sequencer for the execute stage.
- Generalises the fixed single-word ld/st and two-word ldp/stp sequencing into bursts of 1..2^LEN_W words.
- Drives the data-memory port and register-file port, and holds the pipeline via a stall output while a burst runs.
- Sits between execute-stage decode and the shared mem/regs blocks.

---
 rtl/mem_burst_seq.sv | 116 +++++++++++
 tb/tb_mem_burst_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_seq.sv
// mem_burst_seq: multi-cycle load/store burst sequencer for the execute stage.
// Drives the data-memory and register-file ports for bursts of 1..2^LEN_W
// words and holds the pipeline through stall while a burst is in flight.
module mem_burst_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int REG_AW = 4,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_AW-1:0] req_reg,
  input  logic              halt,
  output logic              stall,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wen
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST       = 2'd1,
    LD_ISSUE = 2'd2,
    LD_LAST  = 2'd3
  } state_t;

  localparam logic [LEN_W:0] IDX_ONE = (LEN_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] base_addr;
  logic [REG_AW-1:0] base_reg;
  logic [LEN_W-1:0]  len;
  logic [LEN_W:0]    i;      // issue index
  logic [LEN_W:0]    w;      // writeback index

  logic              last_beat;
  logic              ld_state;
  logic [ADDR_W-1:0] addr_i;
  logic [REG_AW-1:0] reg_i;
  logic [REG_AW-1:0] reg_w;

  // Burst control: accept in IDLE, then step the issue/writeback indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base_addr <= '0;
      base_reg  <= '0;
      len       <= '0;
      i         <= '0;
      w         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_addr <= req_addr;
            base_reg  <= req_reg;
            len       <= req_len;
            i         <= '0;
            w         <= '0;
            state     <= req_store ? ST : LD_ISSUE;
          end
        end
        ST: begin
          if (last_beat) state <= IDLE;
          else           i     <= i + IDX_ONE;
        end
        LD_ISSUE: begin
          // Writeback trails issue by one beat because read data is registered.
          if (i != '0) w <= w + IDX_ONE;
          if (last_beat) state <= LD_LAST;
          else           i     <= i + IDX_ONE;
        end
        LD_LAST: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat address generation; all adds wrap silently at their field width.
  always_comb begin
    last_beat = (i == {1'b0, len});
    ld_state  = (state == LD_ISSUE) || (state == LD_LAST);
    addr_i    = base_addr + ADDR_W'(i);
    reg_i     = base_reg + REG_AW'(i);
    reg_w     = base_reg + REG_AW'(w);
  end

  // Port drive decoded from the registered state; halt gates only the enables.
  always_comb begin
    stall     = ~reset & (req_valid | (state != IDLE));
    done      = ((state == ST) && last_beat) || (state == LD_LAST);
    mem_raddr = ld_state ? addr_i : req_addr;
    mem_waddr = addr_i;
    mem_wdata = reg_rdata;
    mem_wen   = (state == ST) & ~halt;
    reg_raddr = (state == IDLE) ? req_reg : reg_i;
    reg_waddr = reg_w;
    reg_wdata = mem_rdata;
    reg_wen   = (((state == LD_ISSUE) && (i != '0)) || (state == LD_LAST)) & ~halt;
  end

endmodule

// File: tb/tb_mem_burst_seq.sv
// Testbench for mem_burst_seq: behavioural memory and register file, a
// write scoreboard fed at stimulus time, and directed timing checks.
module tb_mem_burst_seq;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_len;
  logic [14:0] req_addr;
  logic [3:0]  req_reg;
  logic        halt;
  logic        stall;
  logic        done;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic [14:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        mem_wen;
  logic [3:0]  reg_raddr;
  logic [15:0] reg_rdata;
  logic [3:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        reg_wen;

  logic [15:0] mem  [32768];
  logic [15:0] regs [16];

  logic [30:0] exp_mem_q [$];   // {addr, data}
  logic [19:0] exp_reg_q [$];   // {reg, data}

  int n_checks = 0;
  int n_fail   = 0;

  mem_burst_seq #(.DATA_W(16), .ADDR_W(15), .REG_AW(4), .LEN_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_store(req_store), .req_len(req_len),
    .req_addr(req_addr), .req_reg(req_reg), .halt(halt),
    .stall(stall), .done(done),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: combinational read.
  assign reg_rdata = regs[reg_raddr];

  // Memory with one-cycle read latency; both arrays take DUT writes.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
    if (reg_wen) regs[reg_waddr] <= reg_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write enable must match the next expected write.
  always @(negedge clk) begin
    logic [30:0] em;
    logic [19:0] er;
    if (mem_wen === 1'b1) begin
      if (exp_mem_q.size() == 0) check("mem_unexpected_write", {17'd0, mem_waddr}, 32'hFFFF_FFFF);
      else begin
        em = exp_mem_q.pop_front();
        check("mem_waddr", {17'd0, mem_waddr}, {17'd0, em[30:16]});
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, em[15:0]});
      end
    end
    if (reg_wen === 1'b1) begin
      if (exp_reg_q.size() == 0) check("reg_unexpected_write", {28'd0, reg_waddr}, 32'hFFFF_FFFF);
      else begin
        er = exp_reg_q.pop_front();
        check("reg_waddr", {28'd0, reg_waddr}, {28'd0, er[19:16]});
        check("reg_wdata", {16'd0, reg_wdata}, {16'd0, er[15:0]});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present a request for one cycle (the accept cycle) and release it.
  task automatic issue(input logic st, input logic [1:0] len, input logic [14:0] a,
                       input logic [3:0] r);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_len = len; req_addr = a; req_reg = r;
    #1;
    check("accept_stall", stall, 1);
    check("accept_done", done, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    logic [14:0] wrap_a [3];
    wrap_a[0] = 15'h7FFF; wrap_a[1] = 15'h0000; wrap_a[2] = 15'h0001;

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_len = '0;
    req_addr = '0; req_reg = '0; halt = 1'b0;
    for (int k = 0; k < 32768; k++) mem[k] = 16'h0;
    for (int k = 0; k < 16; k++) regs[k] = 16'h1000 + 16'(k);
    mem[15'h100] = 16'h0011; mem[15'h101] = 16'h0022;
    mem[15'h102] = 16'h0033; mem[15'h103] = 16'h0044;
    mem[15'h7FFF] = 16'h00A1; mem[15'h0000] = 16'h00A2; mem[15'h0001] = 16'h00A3;
    regs[3] = 16'hBEEF; regs[4] = 16'h1234; regs[10] = 16'hAAAA; regs[11] = 16'hBBBB;

    // Reset state
    repeat (2) cyc();
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_reg_wen", reg_wen, 0);
    reset = 1'b0;
    cyc();
    check("idle_stall", stall, 0);

    // Single-word store
    exp_mem_q.push_back({15'h0010, 16'hBEEF});
    issue(1'b1, 2'd0, 15'h0010, 4'd3);
    cyc();
    check("st1_done", done, 1);
    check("st1_stall", stall, 1);
    check("st1_mem_wen", mem_wen, 1);
    cyc();
    check("st1_after_stall", stall, 0);
    check("st1_after_done", done, 0);

    // Four-word load
    exp_reg_q.push_back({4'd5, 16'h0011});
    exp_reg_q.push_back({4'd6, 16'h0022});
    exp_reg_q.push_back({4'd7, 16'h0033});
    exp_reg_q.push_back({4'd8, 16'h0044});
    issue(1'b0, 2'd3, 15'h0100, 4'd5);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("ld4_raddr", {17'd0, mem_raddr}, {17'd0, 15'h0100 + 15'(k - 1)});
      check("ld4_reg_wen", reg_wen, (k >= 2) ? 1 : 0);
      check("ld4_done", done, 0);
      check("ld4_stall", stall, 1);
    end
    cyc();
    check("ld4_last_wen", reg_wen, 1);
    check("ld4_last_done", done, 1);
    cyc();
    check("ld4_after_stall", stall, 0);

    // Wrap-around load
    exp_reg_q.push_back({4'd15, 16'h00A1});
    exp_reg_q.push_back({4'd0,  16'h00A2});
    exp_reg_q.push_back({4'd1,  16'h00A3});
    issue(1'b0, 2'd2, 15'h7FFF, 4'd15);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("wrap_raddr", {17'd0, mem_raddr}, {17'd0, wrap_a[k]});
    end
    cyc();
    check("wrap_done", done, 1);
    cyc();

    // Halted store: sequence completes, no writes
    halt = 1'b1;
    issue(1'b1, 2'd1, 15'h0040, 4'd2);
    cyc();
    check("halt_c1_wen", mem_wen, 0);
    check("halt_c1_done", done, 0);
    cyc();
    check("halt_c2_wen", mem_wen, 0);
    check("halt_c2_done", done, 1);
    cyc();
    check("halt_idle_stall", stall, 0);
    halt = 1'b0;

    // Reset mid-burst
    issue(1'b0, 2'd3, 15'h0100, 4'd9);
    cyc();
    check("rmid_c1_stall", stall, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rmid_stall", stall, 0);
    check("rmid_reg_wen", reg_wen, 0);
    check("rmid_mem_wen", mem_wen, 0);
    check("rmid_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      cyc();
      check("rmid_post_stall", stall, 0);
      check("rmid_post_wen", reg_wen, 0);
    end
    exp_mem_q.push_back({15'h0020, 16'h1234});
    issue(1'b1, 2'd0, 15'h0020, 4'd4);
    cyc();
    check("rmid_new_done", done, 1);
    check("rmid_new_wen", mem_wen, 1);
    cyc();

    // Back-to-back: store len=1 then load len=0 held valid
    exp_mem_q.push_back({15'h0030, 16'hAAAA});
    exp_mem_q.push_back({15'h0031, 16'hBBBB});
    exp_reg_q.push_back({4'd12, 16'h0033});
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_len = 2'd1; req_addr = 15'h0030; req_reg = 4'd10;
    #1 check("b2b_accept_stall", stall, 1);
    @(posedge clk);
    #1 begin req_store = 1'b0; req_len = 2'd0; req_addr = 15'h0102; req_reg = 4'd12; end
    cyc();
    check("b2b_c1_done", done, 0);
    check("b2b_c1_wen", mem_wen, 1);
    cyc();
    check("b2b_c2_done", done, 1);
    cyc();
    check("b2b_c3_stall", stall, 1);
    check("b2b_c3_done", done, 0);
    check("b2b_c3_wen", mem_wen, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc();
    check("b2b_c4_raddr", {17'd0, mem_raddr}, {17'd0, 15'h0102});
    check("b2b_c4_reg_wen", reg_wen, 0);
    cyc();
    check("b2b_c5_done", done, 1);
    check("b2b_c5_reg_wen", reg_wen, 1);
    cyc();
    check("b2b_after_stall", stall, 0);

    repeat (2) cyc();
    check("mem_q_drained", exp_mem_q.size(), 0);
    check("reg_q_drained", exp_reg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
